// File: rtl/serial_add_ctrl.sv
// Bit-serial W-bit add/subtract sequencing one shared full-adder cell, LSB first; W+1 cycles from start to done.
// No backpressure: start is only taken in IDLE, done pulses once and the result holds until the next completion.

module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);
    assign s = a ^ b ^ cin;
    assign c = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         ovf
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  sha_q, sha_d;
    logic [W-1:0]  shb_q, shb_d;
    logic [W-1:0]  shs_q, shs_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  result_q, result_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic fa_s;
    logic fa_c;

    fa u_fa (
        .a   (sha_q[0]),
        .b   (shb_q[0]),
        .cin (carry_q),
        .s   (fa_s),
        .c   (fa_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sha_q    <= '0;
            shb_q    <= '0;
            shs_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sha_q    <= sha_d;
            shb_q    <= shb_d;
            shs_q    <= shs_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sha_d    = sha_q;
        shb_d    = shb_q;
        shs_d    = shs_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1: invert B and seed the carry.
                    sha_d   = op_a;
                    shb_d   = sub ? ~op_b : op_b;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sha_d   = {1'b0, sha_q[W-1:1]};
                shb_d   = {1'b0, shb_q[W-1:1]};
                shs_d   = {fa_s, shs_q[W-1:1]};
                carry_d = fa_c;
                if (cnt_q == LAST_BIT) begin
                    // carry_q here is the carry into the MSB.
                    result_d = {fa_s, shs_q[W-1:1]};
                    cout_d   = fa_c;
                    ovf_d    = carry_q ^ fa_c;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at W=8: stimulus queues expected results, a monitor checks each done.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    serial_add_ctrl #(.W(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         v;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc[$];
    int   start_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every done pulse against the head of the scoreboard.
    logic prev_done = 1'b0;
    logic in_op = 1'b0;
    logic saw_done = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done = 1'b0;
            in_op = 1'b0;
            saw_done = 1'b0;
        end else begin
            if (done) begin
                exp_t e;
                done_cnt++;
                done_cyc.push_back(cyc);
                checks++;
                if (prev_done) begin
                    errors++;
                    $display("FAIL done_width: done high two cycles in a row at cycle %0d", cyc);
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got result=%h with no pending operation", result);
                end else begin
                    e = sb.pop_front();
                    if (result !== e.r || cout !== e.c || ovf !== e.v) begin
                        errors++;
                        $display("FAIL result: got r=%h c=%b v=%b expected r=%h c=%b v=%b",
                                 result, cout, ovf, e.r, e.c, e.v);
                    end
                end
                saw_done = 1'b1;
            end
            if (busy) in_op = 1'b1;
            if (in_op && !busy) begin
                checks++;
                if (!saw_done) begin
                    errors++;
                    $display("FAIL busy_drop: busy fell before done at cycle %0d", cyc);
                end
                in_op = 1'b0;
                saw_done = 1'b0;
            end
            prev_done = done;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            errors++;
            checks++;
            $display("FAIL idle_timeout: busy still %b after %0d cycles", busy, n);
        end
    endtask

    task automatic push(input logic [W-1:0] r, input logic c, input logic v);
        exp_t e;
        e.r = r;
        e.c = c;
        e.v = v;
        sb.push_back(e);
    endtask

    // Independent arithmetic reference.
    task automatic push_model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0]   sum;
        logic [W-1:0] bb;
        bb  = s ? ~b : b;
        sum = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, s};
        push(sum[W-1:0], sum[W], (a[W-1] == bb[W-1]) && (sum[W-1] != a[W-1]));
    endtask

    // Presents one request in an IDLE cycle; leaves the bench at the negedge after the sampling edge.
    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        wait_idle();
        start = 1'b1;
        sub   = s;
        op_a  = a;
        op_b  = b;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int n;
        int d0;
        start = 1'b0;
        sub   = 1'b0;
        op_a  = '0;
        op_b  = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 0);
        check("reset_done", {31'b0, done}, 0);
        check("reset_result", {24'b0, result}, 0);
        check("reset_flags", {30'b0, cout, ovf}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: add with signed overflow, plus latency measurement.
        push(8'h81, 1'b0, 1'b1);
        issue(1'b0, 8'h3C, 8'h45);
        check("busy_rise", {31'b0, busy}, 1);
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("latency", done_cyc.size() > 0 ? done_cyc[$] - start_cyc : -1, 9);

        // 2 and 3: wrap and subtraction cases.
        push(8'h00, 1'b1, 1'b0);
        issue(1'b0, 8'hFF, 8'h01);
        push(8'hFE, 1'b0, 1'b0);
        issue(1'b1, 8'h05, 8'h07);
        push(8'h7F, 1'b1, 1'b1);
        issue(1'b1, 8'h80, 8'h01);

        // 4: inputs changing during RUN must be ignored.
        wait_idle();
        d0 = done_cnt;
        push(8'h30, 1'b0, 1'b0);
        issue(1'b0, 8'h10, 8'h20);
        repeat (2) @(negedge clk);
        op_a  = 8'hFF;
        op_b  = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("single_done", done_cnt - d0, 1);

        // 4b: start held high for 30 cycles gives three operations, 10 cycles apart.
        d0 = done_cnt;
        op_a = 8'h11;
        op_b = 8'h22;
        sub  = 1'b0;
        repeat (3) push(8'h33, 1'b0, 1'b0);
        start = 1'b1;
        repeat (30) @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("held_count", done_cnt - d0, 3);
        if (done_cnt - d0 == 3) begin
            check("held_gap1", done_cyc[$-1] - done_cyc[$-2], 10);
            check("held_gap2", done_cyc[$] - done_cyc[$-1], 10);
        end

        // 5: asynchronous reset after the 4th RUN edge aborts the operation.
        issue(1'b0, 8'h55, 8'h0F);
        repeat (3) @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_done", {31'b0, done}, 0);
        check("abort_result", {24'b0, result}, 0);
        check("abort_cout", {31'b0, cout}, 0);
        check("abort_ovf", {31'b0, ovf}, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (15) @(negedge clk);
        check("no_done_after_abort", done_cnt - d0, 0);
        push(8'h02, 1'b0, 1'b0);
        issue(1'b0, 8'h01, 8'h01);

        // 6: back-to-back random operations against the arithmetic model.
        for (int i = 0; i < 500; i++) begin
            logic         rs;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            rs = 1'($urandom_range(1, 0));
            ra = W'($urandom);
            rb = W'($urandom);
            wait_idle();
            push_model(rs, ra, rb);
            issue(rs, ra, rb);
        end

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
